alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Decode and operand-fetch stage that sits directly upstream of the ALU. Accepts one RV32I OP or OP-IMM instruction per cycle over a valid/ready handshake, reads a 32x32 register file with write-back bypass, and presents a registered ALU command: `operand1`, `operand2`, 3-bit `opcode`, `is_signed` and the destination register. The register file lives here; the write-back port is driven from downstream.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `NREGS`, 32: register count; x0 reads as zero.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `instr` is valid.
- `in_ready`  out  1  stage can accept `instr` this cycle.
- `instr`  in  32  RV32I instruction word.
- `wb_en`  in  1  register-file write enable.
- `wb_rd`  in  5  write address.
- `wb_data`  in  32  write data.
- `out_valid`  out  1  ALU command is valid.
- `out_ready`  in  1  ALU accepts the command.
- `operand1`  out  32  rs1 value.
- `operand2`  out  32  rs2 value or immediate.
- `opcode`  out  3  ALU operation, equal to instr[14:12].
- `is_signed`  out  1  ALU signed/alternate-operation flag.
- `rd`  out  5  destination register, instr[11:7].
- `illegal`  out  1  the command came from an unsupported instruction.

## Operation
- Accept occurs when `in_valid && in_ready`. `in_ready` = `!out_valid || out_ready`, so there is a single output register and no skid buffer.
- Decode uses major opcode instr[6:0]:
  - 0110011 (OP): `operand2` = rs2 value. `is_signed` = instr[30] for funct3 000 (SUB) and 101 (SRA). `is_signed` = 1 for 010. `is_signed` = 0 otherwise.
  - 0010011 (OP-IMM): `operand2` = sign-extended instr[31:20].
    - Shifts (funct3 001/101) instead use {27'b0, instr[24:20]}.
    - `is_signed` = instr[30] for funct3 101, 1 for 010, 0 otherwise. ADDI never sets it.
    - SLTIU uses the sign-extended immediate, compared unsigned.
- OP funct7 must be 0000000. The only exception is 0100000 with funct3 000 or 101.
- OP-IMM shift funct7 must be 0000000, or 0100000 with funct3 101.
- Any other instruction is illegal. It is still accepted and produces `illegal`=1, `opcode`=000, `operand1`=`operand2`=0, `is_signed`=0, `rd`=0.
- Register read happens in the accept cycle:
  - An index of 0 returns 0.
  - If `wb_en` is high and `wb_rd` equals a nonzero rs index, `wb_data` is forwarded into that operand in the same cycle.
- Register write occurs on the clock edge when `wb_en` is high and `wb_rd` != 0. Writes to x0 are ignored.
- Write-back is independent of the handshake and occurs even while the stage is stalled.
- While `out_valid` is high and `out_ready` is low, all outputs are held stable. A stalled command does not re-read the register file, and a later write-back does not update its operands.

## Timing
- Reset, asynchronous: `out_valid`=0, `operand1`=`operand2`=0, `opcode`=0, `is_signed`=0, `rd`=0, `illegal`=0, all registers 0. `in_ready` is 1 during and after reset.
- Latency: instruction accepted at edge N, command visible after edge N with `out_valid`=1.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Command completes at an edge where `out_valid && out_ready`. If `in_valid` is also high at that edge, the new command loads at that same edge with no bubble.
- `out_valid` falls only at an edge where `out_valid && out_ready && !in_valid`.
- A write-back at edge N is visible to an instruction accepted at edge N via bypass, and to any later one via the array.
- Reset asserted mid-stall drops the held command; no output is produced for it.

## Test plan
- Reset, then write x5=0x0000_0010 and x6=0xFFFF_FFF0, then issue SUB x7,x5,x6 -> one cycle later: `operand1`=0x10, `operand2`=0xFFFF_FFF0, `opcode`=000, `is_signed`=1, `rd`=7, `illegal`=0.
- SRAI x1,x6,4 (instr 0x40435093) -> `operand2`=0x4, `opcode`=101, `is_signed`=1. SLTIU x1,x0,-1 -> `operand2`=0xFFFF_FFFF, `opcode`=011, `is_signed`=0.
- Same-cycle bypass: `wb_en`=1, `wb_rd`=3, `wb_data`=0xDEAD_BEEF while accepting ADD x4,x3,x0 -> `operand1`=0xDEAD_BEEF. Write to x0 with 0x1234, then ADD x1,x0,x0 -> both operands 0.
- Back-pressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 and a write to the stalled command's rs1 -> outputs unchanged, `in_ready`=0. Release -> next instruction appears the cycle after, with no loss or duplication.
- Illegal: instr 0x02208033 (MUL) -> `illegal`=1, operands 0, `rd`=0, `opcode`=000. SLLI with funct7 0100000 -> `illegal`=1.
- Async reset pulse while `out_valid`=1 -> `out_valid` drops immediately. The first instruction after reset reads zeros from all registers.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Decode and operand-fetch stage feeding the ALU: decodes RV32I OP / OP-IMM,
// reads the register file (with write-back bypass) and registers one ALU command.
module alu_operand_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [2:0]      opcode,
  output logic            is_signed,
  output logic [4:0]      rd,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [2:0]      opcode;
    logic            is_signed;
    logic [4:0]      rd;
    logic            illegal;
  } cmd_t;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rs1_val, rs2_val;
  cmd_t            cmd_d, cmd_q;
  logic            accept;

  logic [6:0] major, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2;

  assign major  = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Register read with same-cycle forwarding of the write-back port; x0 is never forwarded.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != '0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
    if (rs2 != '0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
  end

  // NOTE: every variable gets a default before the case split, so no path can infer a latch.
  always_comb begin
    cmd_d         = '0;
    cmd_d.illegal = 1'b1;
    unique case (major)
      OPC_OP: begin
        if (funct7 == F7_ZERO ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          cmd_d.illegal   = 1'b0;
          cmd_d.operand1  = rs1_val;
          cmd_d.operand2  = rs2_val;
          cmd_d.opcode    = funct3;
          cmd_d.rd        = instr[11:7];
          cmd_d.is_signed = (funct3 == 3'b000 || funct3 == 3'b101) ? instr[30]
                          : (funct3 == 3'b010);
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (funct7 == F7_ZERO || (funct7 == F7_ALT && funct3 == 3'b101)) begin
            cmd_d.illegal   = 1'b0;
            cmd_d.operand1  = rs1_val;
            cmd_d.operand2  = {{(XLEN-5){1'b0}}, instr[24:20]};
            cmd_d.opcode    = funct3;
            cmd_d.rd        = instr[11:7];
            cmd_d.is_signed = (funct3 == 3'b101) && instr[30];
          end
        end else begin
          // Immediate instructions (including SLTIU) always use the sign-extended immediate.
          cmd_d.illegal   = 1'b0;
          cmd_d.operand1  = rs1_val;
          cmd_d.operand2  = {{(XLEN-12){instr[31]}}, instr[31:20]};
          cmd_d.opcode    = funct3;
          cmd_d.rd        = instr[11:7];
          cmd_d.is_signed = (funct3 == 3'b010);
        end
      end
      default: ;
    endcase
  end

  // NOTE: the register file is reset with the rest of the stage because x1..x31 must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      cmd_q     <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (accept) cmd_q <= cmd_d;
    end
  end

  assign operand1  = cmd_q.operand1;
  assign operand2  = cmd_q.operand2;
  assign opcode    = cmd_q.opcode;
  assign is_signed = cmd_q.is_signed;
  assign rd        = cmd_q.rd;
  assign illegal   = cmd_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  opcode;
  logic        is_signed;
  logic [4:0]  rd;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand1(operand1), .operand2(operand2), .opcode(opcode),
    .is_signed(is_signed), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d, input logic [6:0] op);
    return {f7, s2, s1, f3, d, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d,
                                        input logic [6:0] op);
    return {imm, s1, f3, d, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_cmd(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                            input logic [2:0] opc, input logic sgn, input logic [4:0] d,
                            input logic ill);
    check({tag, ".out_valid"}, out_valid, 1'b1);
    check({tag, ".operand1"},  operand1,  op1);
    check({tag, ".operand2"},  operand2,  op2);
    check({tag, ".opcode"},    opcode,    opc);
    check({tag, ".is_signed"}, is_signed, sgn);
    check({tag, ".rd"},        rd,        d);
    check({tag, ".illegal"},   illegal,   ill);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    #3;
    check("reset.in_ready", in_ready, 1'b1);
    #9 rst_n = 1'b1;
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.operand1", operand1, 32'h0);
    check("reset.operand2", operand2, 32'h0);
    check("reset.rd", rd, 5'd0);
    check("reset.illegal", illegal, 1'b0);

    // Load x5, x6 through the write-back port.
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_0010; tick();
    wb_rd = 5'd6; wb_data = 32'hFFFF_FFF0; tick();
    wb_en = 1'b0;

    in_valid = 1'b1;
    instr = enc_r(7'b0100000, 5'd6, 5'd5, 3'b000, 5'd7, OP); tick();
    expect_cmd("sub", 32'h10, 32'hFFFF_FFF0, 3'b000, 1'b1, 5'd7, 1'b0);

    instr = 32'h40435093; tick();
    expect_cmd("srai", 32'hFFFF_FFF0, 32'h4, 3'b101, 1'b1, 5'd1, 1'b0);

    instr = enc_i(12'hFFF, 5'd0, 3'b011, 5'd1, OP_IMM); tick();
    expect_cmd("sltiu", 32'h0, 32'hFFFF_FFFF, 3'b011, 1'b0, 5'd1, 1'b0);

    instr = enc_r(7'b0100000, 5'd5, 5'd6, 3'b101, 5'd2, OP); tick();
    expect_cmd("sra", 32'hFFFF_FFF0, 32'h10, 3'b101, 1'b1, 5'd2, 1'b0);

    instr = enc_r(7'b0000000, 5'd6, 5'd5, 3'b010, 5'd2, OP); tick();
    expect_cmd("slt", 32'h10, 32'hFFFF_FFF0, 3'b010, 1'b1, 5'd2, 1'b0);

    instr = enc_i(12'h400, 5'd5, 3'b000, 5'd3, OP_IMM); tick();
    expect_cmd("addi", 32'h10, 32'h400, 3'b000, 1'b0, 5'd3, 1'b0);

    instr = enc_i({7'b0000000, 5'd31}, 5'd6, 3'b101, 5'd3, OP_IMM); tick();
    expect_cmd("srli", 32'hFFFF_FFF0, 32'd31, 3'b101, 1'b0, 5'd3, 1'b0);

    // Same-cycle bypass, then the written value through the array.
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    instr = enc_r(7'b0, 5'd0, 5'd3, 3'b000, 5'd4, OP); tick();
    wb_en = 1'b0;
    expect_cmd("bypass", 32'hDEAD_BEEF, 32'h0, 3'b000, 1'b0, 5'd4, 1'b0);

    instr = enc_r(7'b0, 5'd3, 5'd0, 3'b000, 5'd4, OP); tick();
    expect_cmd("array_x3", 32'h0, 32'hDEAD_BEEF, 3'b000, 1'b0, 5'd4, 1'b0);

    // x0 writes are neither forwarded nor stored.
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
    instr = enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd1, OP); tick();
    wb_en = 1'b0;
    expect_cmd("x0_bypass", 32'h0, 32'h0, 3'b000, 1'b0, 5'd1, 1'b0);
    instr = enc_r(7'b0, 5'd0, 5'd0, 3'b000, 5'd1, OP); tick();
    expect_cmd("x0_array", 32'h0, 32'h0, 3'b000, 1'b0, 5'd1, 1'b0);

    // Back-pressure with a write to the stalled command's rs1.
    instr = enc_r(7'b0, 5'd6, 5'd5, 3'b000, 5'd8, OP); tick();
    out_ready = 1'b0;
    instr = enc_r(7'b0, 5'd0, 5'd5, 3'b000, 5'd9, OP);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    #1;
    check("stall.in_ready0", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_cmd("stall", 32'h10, 32'hFFFF_FFF0, 3'b000, 1'b0, 5'd8, 1'b0);
      check("stall.in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1; wb_en = 1'b0; tick();
    expect_cmd("release", 32'h55, 32'h0, 3'b000, 1'b0, 5'd9, 1'b0);
    in_valid = 1'b0; tick();
    check("drain.out_valid", out_valid, 1'b0);
    tick();
    check("idle.out_valid", out_valid, 1'b0);

    // Illegal encodings.
    in_valid = 1'b1;
    instr = 32'h02208033; tick();
    expect_cmd("mul", 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b1);
    instr = enc_r(7'b0000001, 5'd6, 5'd5, 3'b000, 5'd7, OP); tick();
    expect_cmd("bad_f7", 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b1);
    instr = enc_i({7'b0100000, 5'd3}, 5'd5, 3'b001, 5'd1, OP_IMM); tick();
    expect_cmd("slli_alt", 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b1);
    instr = enc_i(12'h0, 5'd5, 3'b010, 5'd3, 7'b0000011); tick();
    expect_cmd("load", 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 1'b1);
    instr = enc_r(7'b0, 5'd6, 5'd5, 3'b000, 5'd8, OP); tick();
    expect_cmd("after_illegal", 32'h55, 32'hFFFF_FFF0, 3'b000, 1'b0, 5'd8, 1'b0);

    // Asynchronous reset while a command is held.
    out_ready = 1'b0; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst.out_valid", out_valid, 1'b0);
    check("arst.in_ready", in_ready, 1'b1);
    check("arst.operand1", operand1, 32'h0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1;
    instr = enc_r(7'b0, 5'd6, 5'd5, 3'b000, 5'd1, OP); tick();
    expect_cmd("post_reset", 32'h0, 32'h0, 3'b000, 1'b0, 5'd1, 1'b0);
    instr = enc_r(7'b0, 5'd4, 5'd3, 3'b000, 5'd2, OP); tick();
    expect_cmd("post_reset2", 32'h0, 32'h0, 3'b000, 1'b0, 5'd2, 1'b0);
    in_valid = 1'b0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
